// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Purpose  : Shared types and constants for the IFU memory-side arbiter.
// Revision : 1.0
// ============================================================================
package ifu_pkg;

    localparam int DEF_TAG_WIDTH       = 28;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int OST_IDX_W           = $clog2(DEF_MAX_OUTSTANDING);
    localparam int PF_DROP_CNT_W       = 16;

    typedef struct packed {
        logic                     valid;
        logic [DEF_TAG_WIDTH-1:0] tag;
        logic                     is_miss;
    } ost_entry_t;

    function automatic logic [PF_DROP_CNT_W-1:0] sat_inc(input logic [PF_DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_ost_table.sv
`default_nettype none
// ============================================================================
// Module   : ifu_ost_table
// Purpose  : Outstanding-request table with request/response CAM lookups,
//            lowest-free allocation and free/valid counts.
// Revision : 1.0
// ============================================================================
module ifu_ost_table
    import ifu_pkg::*;
#(
    parameter  int TAG_WIDTH       = 28,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int IDX_W           = $clog2(MAX_OUTSTANDING),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic [TAG_WIDTH-1:0] rsp_tag,
    input  logic                 rsp_valid,
    input  logic                 alloc_en,
    input  logic                 alloc_is_miss,
    input  logic                 merge_en,
    output logic                 req_hit,
    output logic                 rsp_hit,
    output logic                 rsp_is_miss,
    output logic                 free_any,
    output logic [CNT_W-1:0]     free_cnt,
    output logic [CNT_W-1:0]     count
);

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
        logic                 is_miss;
    } entry_t;

    entry_t                     ent [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] valid_vec;
    logic [MAX_OUTSTANDING-1:0] rsp_match;
    logic [MAX_OUTSTANDING-1:0] req_match;
    logic [MAX_OUTSTANDING-1:0] freed;
    logic [MAX_OUTSTANDING-1:0] alloc_oh;
    logic [MAX_OUTSTANDING-1:0] next_valid;
    logic [IDX_W-1:0]           alloc_idx;
    logic [CNT_W-1:0]           next_count;

    always_comb begin
        valid_vec   = '0;
        rsp_match   = '0;
        req_match   = '0;
        alloc_oh    = '0;
        alloc_idx   = '0;
        free_any    = 1'b0;
        free_cnt    = '0;
        rsp_is_miss = 1'b0;
        next_count  = '0;

        // Descending scan so the last write leaves the lowest free index.
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            valid_vec[i] = ent[i].valid;
            rsp_match[i] = ent[i].valid && (ent[i].tag == rsp_tag);
            if (!ent[i].valid) begin
                alloc_idx = IDX_W'(i);
                free_any  = 1'b1;
                free_cnt  = free_cnt + 1'b1;
            end
        end

        freed = rsp_valid ? rsp_match : '0;

        // An entry retiring this cycle cannot absorb a merge.
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            req_match[i] = ent[i].valid && (ent[i].tag == req_tag) && !freed[i];
            if (freed[i]) begin
                rsp_is_miss = rsp_is_miss | ent[i].is_miss;
            end
        end

        rsp_hit = |freed;
        req_hit = |req_match;

        if (alloc_en) begin
            alloc_oh[alloc_idx] = 1'b1;
        end
        next_valid = (valid_vec & ~freed) | alloc_oh;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            next_count = next_count + CNT_W'(next_valid[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                ent[i] <= '0;
            end
            count <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (freed[i]) begin
                    ent[i].valid <= 1'b0;
                end
                if (alloc_oh[i]) begin
                    ent[i] <= '{valid: 1'b1, tag: req_tag, is_miss: alloc_is_miss};
                end
                if (merge_en && req_match[i]) begin
                    ent[i].is_miss <= 1'b1;
                end
            end
            count <= next_count;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifu_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : ifu_mem_arb
// Purpose  : Miss/prefetch arbiter with outstanding-request tracking,
//            duplicate merging and tagged fill routing to the IFU cache.
// Revision : 1.0
// ============================================================================
module ifu_mem_arb
    import ifu_pkg::*;
#(
    parameter  int TAG_WIDTH       = 28,
    parameter  int LINE_WIDTH      = 128,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int PF_RESERVE      = 1,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     Clock,
    input  logic                     Rst,
    input  logic [TAG_WIDTH-1:0]     miss_reqTagIn,
    input  logic                     miss_reqValidIn,
    output logic                     miss_reqReadyOut,
    input  logic [TAG_WIDTH-1:0]     pf_reqTagIn,
    input  logic                     pf_reqValidIn,
    output logic                     pf_reqReadyOut,
    output logic [TAG_WIDTH-1:0]     mem_reqTagOut,
    output logic                     mem_reqValidOut,
    input  logic                     mem_reqReadyIn,
    input  logic [TAG_WIDTH-1:0]     mem_rspTagIn,
    input  logic [LINE_WIDTH-1:0]    mem_rspInsLineIn,
    input  logic                     mem_rspValidIn,
    output logic [TAG_WIDTH-1:0]     fill_tagOut,
    output logic [LINE_WIDTH-1:0]    fill_lineOut,
    output logic                     fill_validOut,
    output logic                     fill_isPrefetchOut,
    output logic [CNT_W-1:0]         outstandingCountOut,
    output logic [PF_DROP_CNT_W-1:0] pfDropCountOut,
    output logic                     spuriousRspOut
);

    logic [TAG_WIDTH-1:0] req_tag;
    logic                 req_hit;
    logic                 rsp_hit;
    logic                 rsp_is_miss;
    logic                 free_any;
    logic [CNT_W-1:0]     free_cnt;
    logic                 issue_free;
    logic                 fwd;
    logic                 miss_fwd;
    logic                 miss_alloc;
    logic                 pf_active;
    logic                 pf_drop;
    logic                 pf_alloc;
    logic                 alloc_en;
    logic                 merge_en;

    always_comb begin
        // A pending miss owns the shared lookup port; prefetches wait.
        req_tag    = miss_reqValidIn ? miss_reqTagIn : pf_reqTagIn;
        issue_free = !mem_reqValidOut || mem_reqReadyIn;
        fwd        = rsp_hit && (req_tag == mem_rspTagIn);

        miss_fwd   = miss_reqValidIn && !req_hit && fwd;
        miss_alloc = miss_reqValidIn && !req_hit && !fwd && free_any && issue_free;
        merge_en   = miss_reqValidIn && req_hit;

        pf_active  = !miss_reqValidIn && pf_reqValidIn;
        pf_drop    = pf_active && (req_hit || fwd);
        pf_alloc   = pf_active && !req_hit && !fwd
                     && (int'(free_cnt) > PF_RESERVE) && issue_free;

        alloc_en   = miss_alloc || pf_alloc;

        miss_reqReadyOut = Rst && miss_reqValidIn
                           && (req_hit || fwd || (free_any && issue_free));
        pf_reqReadyOut   = Rst && (pf_drop || pf_alloc);
    end

    ifu_ost_table #(
        .TAG_WIDTH       (TAG_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_table (
        .clk           (Clock),
        .rst_n         (Rst),
        .req_tag       (req_tag),
        .rsp_tag       (mem_rspTagIn),
        .rsp_valid     (mem_rspValidIn),
        .alloc_en      (alloc_en),
        .alloc_is_miss (miss_alloc),
        .merge_en      (merge_en),
        .req_hit       (req_hit),
        .rsp_hit       (rsp_hit),
        .rsp_is_miss   (rsp_is_miss),
        .free_any      (free_any),
        .free_cnt      (free_cnt),
        .count         (outstandingCountOut)
    );

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            mem_reqValidOut    <= 1'b0;
            mem_reqTagOut      <= '0;
            fill_validOut      <= 1'b0;
            fill_tagOut        <= '0;
            fill_lineOut       <= '0;
            fill_isPrefetchOut <= 1'b0;
            pfDropCountOut     <= '0;
            spuriousRspOut     <= 1'b0;
        end else begin
            if (alloc_en) begin
                mem_reqValidOut <= 1'b1;
                mem_reqTagOut   <= req_tag;
            end else if (mem_reqReadyIn) begin
                mem_reqValidOut <= 1'b0;
            end

            fill_validOut <= rsp_hit;
            if (rsp_hit) begin
                fill_tagOut        <= mem_rspTagIn;
                fill_lineOut       <= mem_rspInsLineIn;
                fill_isPrefetchOut <= !rsp_is_miss && !miss_fwd;
            end

            if (pf_drop) begin
                pfDropCountOut <= sat_inc(pfDropCountOut);
            end
            if (mem_rspValidIn && !rsp_hit) begin
                spuriousRspOut <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_mem_arb.sv
`default_nettype none
// Bench for ifu_mem_arb: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ifu_mem_arb;

    localparam int TW   = 28;
    localparam int LW   = 128;
    localparam int MAXO = 4;
    localparam int PFR  = 1;
    localparam int CW   = $clog2(MAXO + 1);

    logic          Clock = 1'b0;
    logic          Rst   = 1'b0;
    logic [TW-1:0] miss_tag = '0;
    logic          miss_valid = 1'b0;
    logic          miss_ready;
    logic [TW-1:0] pf_tag = '0;
    logic          pf_valid = 1'b0;
    logic          pf_ready;
    logic [TW-1:0] mem_tag;
    logic          mem_valid;
    logic          mem_ready = 1'b1;
    logic [TW-1:0] rsp_tag = '0;
    logic [LW-1:0] rsp_line = '0;
    logic          rsp_valid = 1'b0;
    logic [TW-1:0] fill_tag;
    logic [LW-1:0] fill_line;
    logic          fill_valid;
    logic          fill_pf;
    logic [CW-1:0] ost_count;
    logic [15:0]   drop_count;
    logic          spurious;

    int checks = 0;
    int errors = 0;
    int n_issue = 0;

    ifu_mem_arb #(
        .TAG_WIDTH(TW), .LINE_WIDTH(LW), .MAX_OUTSTANDING(MAXO), .PF_RESERVE(PFR)
    ) dut (
        .Clock               (Clock),
        .Rst                 (Rst),
        .miss_reqTagIn       (miss_tag),
        .miss_reqValidIn     (miss_valid),
        .miss_reqReadyOut    (miss_ready),
        .pf_reqTagIn         (pf_tag),
        .pf_reqValidIn       (pf_valid),
        .pf_reqReadyOut      (pf_ready),
        .mem_reqTagOut       (mem_tag),
        .mem_reqValidOut     (mem_valid),
        .mem_reqReadyIn      (mem_ready),
        .mem_rspTagIn        (rsp_tag),
        .mem_rspInsLineIn    (rsp_line),
        .mem_rspValidIn      (rsp_valid),
        .fill_tagOut         (fill_tag),
        .fill_lineOut        (fill_line),
        .fill_validOut       (fill_valid),
        .fill_isPrefetchOut  (fill_pf),
        .outstandingCountOut (ost_count),
        .pfDropCountOut      (drop_count),
        .spuriousRspOut      (spurious)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] line_of(input logic [TW-1:0] t);
        return {4{4'hA, t}};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [TW-1:0] tag;
        logic          is_miss;
    } ment_t;

    ment_t         ost[$];
    logic          m_req_valid;
    logic [TW-1:0] m_req_tag;
    logic          m_fill_valid;
    logic [TW-1:0] m_fill_tag;
    logic [LW-1:0] m_fill_line;
    logic          m_fill_pf;
    int            m_drop;
    logic          m_spur;

    logic c_rsp_hit, c_rsp_miss, c_fwd, c_hit, e_miss_ready, e_pf_ready;

    function automatic int find(input logic [TW-1:0] t);
        foreach (ost[i]) if (ost[i].tag == t) return i;
        return -1;
    endfunction

    task automatic clear_model();
        ost.delete();
        m_req_valid  = 1'b0;
        m_req_tag    = '0;
        m_fill_valid = 1'b0;
        m_fill_tag   = '0;
        m_fill_line  = '0;
        m_fill_pf    = 1'b0;
        m_drop       = 0;
        m_spur       = 1'b0;
    endtask

    function automatic void calc();
        int            ri;
        int            qi;
        int            nfree;
        logic          ifree;
        logic [TW-1:0] t;
        t            = miss_valid ? miss_tag : pf_tag;
        ri           = find(rsp_tag);
        qi           = find(t);
        nfree        = MAXO - ost.size();
        ifree        = !m_req_valid || mem_ready;
        c_rsp_hit    = rsp_valid && (ri >= 0);
        c_rsp_miss   = (ri >= 0) ? ost[ri].is_miss : 1'b0;
        c_fwd        = c_rsp_hit && (t == rsp_tag);
        c_hit        = (qi >= 0) && !c_fwd;
        e_miss_ready = Rst && miss_valid && (c_hit || c_fwd || (nfree > 0 && ifree));
        e_pf_ready   = Rst && !miss_valid && pf_valid && (c_hit || c_fwd || (nfree > PFR && ifree));
    endfunction

    always @(negedge Rst) clear_model();

    always @(posedge Clock) begin : model_upd
        logic [TW-1:0] t;
        bit            alloc;
        int            idx;
        if (Rst) begin
            calc();
            t     = miss_valid ? miss_tag : pf_tag;
            alloc = 1'b0;
            m_fill_valid = c_rsp_hit;
            if (c_rsp_hit) begin
                idx         = find(rsp_tag);
                m_fill_tag  = rsp_tag;
                m_fill_line = rsp_line;
                m_fill_pf   = !c_rsp_miss && !(miss_valid && c_fwd);
                ost.delete(idx);
            end
            if (rsp_valid && !c_rsp_hit) m_spur = 1'b1;
            if (miss_valid) begin
                if (c_hit) begin
                    idx = find(t);
                    ost[idx].is_miss = 1'b1;
                end else if (!c_fwd && e_miss_ready) begin
                    ost.push_back('{t, 1'b1});
                    alloc = 1'b1;
                end
            end else if (pf_valid) begin
                if (c_hit || c_fwd) begin
                    if (m_drop < 65535) m_drop++;
                end else if (e_pf_ready) begin
                    ost.push_back('{t, 1'b0});
                    alloc = 1'b1;
                end
            end
            if (alloc) begin
                m_req_valid = 1'b1;
                m_req_tag   = t;
            end else if (mem_ready) begin
                m_req_valid = 1'b0;
            end
        end
    end

    always @(posedge Clock) if (Rst && mem_valid && mem_ready) n_issue++;

    // ---------------- per-cycle comparison ----------------
    always @(negedge Clock) begin
        calc();
        if (miss_valid) chk("miss_ready", miss_ready, e_miss_ready);
        if (pf_valid)   chk("pf_ready", pf_ready, e_pf_ready);
        chk("mem_valid", mem_valid, m_req_valid);
        if (m_req_valid) chk("mem_tag", mem_tag, m_req_tag);
        chk("fill_valid", fill_valid, m_fill_valid);
        if (m_fill_valid) begin
            chk("fill_tag", fill_tag, m_fill_tag);
            chk("fill_line", fill_line, m_fill_line);
            chk("fill_pf", fill_pf, m_fill_pf);
        end
        chk("count", ost_count, LW'(ost.size()));
        chk("drop", drop_count, LW'(m_drop));
        chk("spurious", spurious, m_spur);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic send_rsp(input logic [TW-1:0] t);
        rsp_valid = 1'b1;
        rsp_tag   = t;
        rsp_line  = line_of(t);
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic send_miss(input logic [TW-1:0] t);
        miss_valid = 1'b1;
        miss_tag   = t;
        tick();
        miss_valid = 1'b0;
    endtask

    int base;

    initial begin
        clear_model();
        repeat (3) tick();
        chk("rst_count", ost_count, 0);
        chk("rst_memv", mem_valid, 0);
        chk("rst_fillv", fill_valid, 0);
        chk("rst_spur", spurious, 0);
        Rst = 1'b1;
        tick();

        // single miss round trip
        miss_valid = 1'b1; miss_tag = 'h10;
        #1 chk("s1_ready", miss_ready, 1);
        tick();
        miss_valid = 1'b0;
        chk("s1_memv", mem_valid, 1);
        chk("s1_memtag", mem_tag, 'h10);
        chk("s1_count1", ost_count, 1);
        tick();
        send_rsp('h10);
        chk("s1_fillv", fill_valid, 1);
        chk("s1_filltag", fill_tag, 'h10);
        chk("s1_fillline", fill_line, line_of('h10));
        chk("s1_fillpf", fill_pf, 0);
        tick();
        chk("s1_count0", ost_count, 0);
        chk("s1_fill_strobe", fill_valid, 0);

        // prefetch then merging miss
        base = n_issue;
        pf_valid = 1'b1; pf_tag = 'h20;
        #1 chk("s2_pfready", pf_ready, 1);
        tick();
        pf_valid = 1'b0;
        miss_valid = 1'b1; miss_tag = 'h20;
        #1 chk("s2_merge", miss_ready, 1);
        tick();
        miss_valid = 1'b0;
        tick();
        chk("s2_issues", n_issue - base, 1);
        send_rsp('h20);
        chk("s2_filltag", fill_tag, 'h20);
        chk("s2_fillpf", fill_pf, 0);

        // prefetch dropped against outstanding miss
        base = n_issue;
        send_miss('h30);
        pf_valid = 1'b1; pf_tag = 'h30;
        #1 chk("s3_pfready", pf_ready, 1);
        tick();
        pf_valid = 1'b0;
        chk("s3_drop", drop_count, 1);
        chk("s3_issues", n_issue - base, 1);
        send_rsp('h30);

        // table fill and prefetch reserve
        miss_valid = 1'b1;
        miss_tag = 'h11; tick();
        miss_tag = 'h12; tick();
        miss_tag = 'h13; tick();
        miss_valid = 1'b0;
        chk("s4_count3", ost_count, 3);
        pf_valid = 1'b1; pf_tag = 'h40;
        #1 chk("s4_pf_reserved", pf_ready, 0);
        tick();
        pf_valid = 1'b0;
        miss_valid = 1'b1; miss_tag = 'h41;
        #1 chk("s4_miss41", miss_ready, 1);
        tick();
        chk("s4_count4", ost_count, 4);
        miss_tag = 'h42;
        #1 chk("s4_full", miss_ready, 0);
        tick();
        miss_valid = 1'b0;

        // memory back-pressure
        send_rsp('h13);
        mem_ready = 1'b0;
        miss_valid = 1'b1; miss_tag = 'h50;
        #1 chk("s5_alloc50", miss_ready, 1);
        tick();
        miss_valid = 1'b0;
        chk("s5_memtag", mem_tag, 'h50);
        send_rsp('h41);
        for (int i = 0; i < 4; i++) begin
            miss_valid = 1'b1; miss_tag = 'h51;
            #1 chk("s5_blocked", miss_ready, 0);
            chk("s5_stable", mem_tag, 'h50);
            tick();
        end
        miss_tag = 'h11;
        #1 chk("s5_merge_ok", miss_ready, 1);
        tick();
        miss_valid = 1'b0;
        chk("s5_held", mem_valid, 1);
        mem_ready = 1'b1;
        tick();
        chk("s5_released", mem_valid, 0);

        // out-of-order responses
        send_rsp('h12);
        chk("s6_fill12", fill_tag, 'h12);
        send_rsp('h11);
        chk("s6_fill11", fill_tag, 'h11);
        send_rsp('h50);
        tick();
        chk("s6_empty", ost_count, 0);

        // forward-merge onto a retiring prefetch entry
        pf_valid = 1'b1; pf_tag = 'h70; tick(); pf_valid = 1'b0;
        miss_valid = 1'b1; miss_tag = 'h70;
        rsp_valid = 1'b1; rsp_tag = 'h70; rsp_line = line_of('h70);
        #1 chk("s6_fwd_ready", miss_ready, 1);
        tick();
        miss_valid = 1'b0; rsp_valid = 1'b0;
        chk("s6_fwd_pf", fill_pf, 0);
        chk("s6_fwd_count", ost_count, 0);

        // pure prefetch fill
        pf_valid = 1'b1; pf_tag = 'h71; tick(); pf_valid = 1'b0;
        tick();
        send_rsp('h71);
        chk("s6_pf_fill", fill_pf, 1);

        // spurious response
        send_rsp('h99);
        chk("s6_spur", spurious, 1);
        chk("s6_spur_nofill", fill_valid, 0);

        // asynchronous reset mid-flight
        send_miss('h80);
        chk("s7_pre_memv", mem_valid, 1);
        #1 Rst = 1'b0;
        #1;
        chk("s7_memv", mem_valid, 0);
        chk("s7_count", ost_count, 0);
        chk("s7_spur", spurious, 0);
        chk("s7_drop", drop_count, 0);
        tick();
        tick();
        Rst = 1'b1;
        tick();
        send_rsp('h80);
        chk("s7_stale_spur", spurious, 1);
        chk("s7_stale_nofill", fill_valid, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
